// File: rtl/pc_sequencer.sv
// Program-counter sequencer: sequential fetch under an imem handshake, hazard
// stalls, taken-jump redirect with flush bubbles, and halt at the exit address.
module pc_sequencer #(
  parameter int              PC_W         = 8,
  parameter logic [PC_W-1:0] RESET_PC     = 8'h04,
  parameter int              PC_STEP      = 4,
  parameter int              FLUSH_CYCLES = 2,
  parameter logic [PC_W-1:0] HALT_PC      = 8'h80
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            senable,
  input  logic [PC_W-1:0] etq,
  input  logic            stall,
  input  logic            imem_ready,
  output logic [PC_W-1:0] pc,
  output logic            fetch_req,
  output logic            flush,
  output logic            halted,
  output logic [7:0]      jump_count
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      flush_cnt;
  logic [PC_W-1:0] next_pc;

  assign next_pc = pc + PC_W'(PC_STEP);

  assign fetch_req = (state == FETCH) & ~stall & rst_n;
  assign flush     = (state == FLUSH);
  assign halted    = (state == HALT);

  // A jump outranks stall and the memory handshake; the fetch it displaces is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      flush_cnt  <= 4'd0;
      jump_count <= 8'd0;
    end else begin
      case (state)
        FETCH: begin
          if (senable) begin
            pc        <= etq;
            flush_cnt <= 4'(FLUSH_CYCLES - 1);
            if (jump_count != 8'hFF)
              jump_count <= jump_count + 8'd1;
            state     <= FLUSH;
          end else if (!stall && imem_ready) begin
            pc <= next_pc;
            if (next_pc == HALT_PC)
              state <= HALT;
          end
        end
        FLUSH: begin
          if (flush_cnt == 4'd0)
            state <= (pc == HALT_PC) ? HALT : FETCH;
          else
            flush_cnt <= flush_cnt - 4'd1;
        end
        HALT: begin
          state <= HALT;
        end
        default: begin
          state <= FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected output snapshots are queued as
// stimulus is applied and compared after each rising edge.
module tb_pc_sequencer;

  typedef struct packed {
    logic [7:0] pc;
    logic       fr;
    logic       fl;
    logic       h;
    logic [7:0] jc;
  } snap_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       senable = 1'b0;
  logic [7:0] etq = 8'h00;
  logic       stall = 1'b0;
  logic       imem_ready = 1'b0;
  logic [7:0] pc;
  logic       fetch_req;
  logic       flush;
  logic       halted;
  logic [7:0] jump_count;

  int    checks = 0;
  int    errors = 0;
  snap_t sb[$];

  pc_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .senable    (senable),
    .etq        (etq),
    .stall      (stall),
    .imem_ready (imem_ready),
    .pc         (pc),
    .fetch_req  (fetch_req),
    .flush      (flush),
    .halted     (halted),
    .jump_count (jump_count)
  );

  always #5 clk = ~clk;

  function automatic snap_t mk(input logic [7:0] p, input logic fr, input logic fl,
                               input logic h, input logic [7:0] jc);
    mk = '{pc: p, fr: fr, fl: fl, h: h, jc: jc};
  endfunction

  function automatic snap_t observed();
    observed = '{pc: pc, fr: fetch_req, fl: flush, h: halted, jc: jump_count};
  endfunction

  // Apply one cycle of inputs, then move to 1 time unit past the rising edge.
  task automatic tick(input logic se, input logic [7:0] t, input logic st, input logic rd);
    senable    = se;
    etq        = t;
    stall      = st;
    imem_ready = rd;
    @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rst_n = 1'b0;
    senable = 1'b0; stall = 1'b0; imem_ready = 1'b0;
    #7;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    snap_t e, o;
    imem_ready = 1'b1;
    #12;
    sb.push_back(mk(8'h04, 1'b0, 1'b0, 1'b0, 8'd0));
    e = sb.pop_front(); o = observed(); checks++;
    if (o !== e) begin
      errors++;
      $display("[TB] FAIL reset_hold: got %p required %p", o, e);
    end
    rst_n = 1'b1;
    #1;
    sb.push_back(mk(8'h04, 1'b1, 1'b0, 1'b0, 8'd0));
    e = sb.pop_front(); o = observed(); checks++;
    if (o !== e) begin
      errors++;
      $display("[TB] FAIL reset_release: got %p required %p", o, e);
    end
  endtask

  task automatic test_free_run();
    snap_t e, o;
    logic [7:0] exp_pc [3] = '{8'h08, 8'h0C, 8'h10};
    for (int i = 0; i < 3; i++) begin
      sb.push_back(mk(exp_pc[i], 1'b1, 1'b0, 1'b0, 8'd0));
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      e = sb.pop_front(); o = observed(); checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL free_run[%0d]: got %p required %p", i, o, e);
      end
    end
  endtask

  task automatic test_jump();
    snap_t e, o;
    sb.push_back(mk(8'h38, 1'b0, 1'b1, 1'b0, 8'd1));
    tick(1'b1, 8'h38, 1'b0, 1'b1);
    sb.push_back(mk(8'h38, 1'b0, 1'b1, 1'b0, 8'd1));
    sb.push_back(mk(8'h38, 1'b1, 1'b0, 1'b0, 8'd1));
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick(1'b0, 8'h00, 1'b0, 1'b1);
      e = sb.pop_front(); o = observed(); checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL jump[%0d]: got %p required %p", i, o, e);
      end
    end
  endtask

  task automatic test_stall_handshake();
    snap_t e, o;
    // Redirect to 0x50 first, then exercise stall and the ready handshake there.
    for (int i = 0; i < 11; i++) begin
      case (i)
        0: begin sb.push_back(mk(8'h50, 1'b0, 1'b1, 1'b0, 8'd2)); tick(1'b1, 8'h50, 1'b0, 1'b0); end
        1: begin sb.push_back(mk(8'h50, 1'b0, 1'b1, 1'b0, 8'd2)); tick(1'b0, 8'h00, 1'b0, 1'b0); end
        2: begin sb.push_back(mk(8'h50, 1'b1, 1'b0, 1'b0, 8'd2)); tick(1'b0, 8'h00, 1'b0, 1'b0); end
        3, 4, 5: begin sb.push_back(mk(8'h50, 1'b0, 1'b0, 1'b0, 8'd2)); tick(1'b0, 8'h00, 1'b1, 1'b1); end
        6, 7: begin sb.push_back(mk(8'h50, 1'b1, 1'b0, 1'b0, 8'd2)); tick(1'b0, 8'h00, 1'b0, 1'b0); end
        8: begin sb.push_back(mk(8'h54, 1'b1, 1'b0, 1'b0, 8'd2)); tick(1'b0, 8'h00, 1'b0, 1'b1); end
        default: begin sb.push_back(mk(8'h54, 1'b1, 1'b0, 1'b0, 8'd2)); tick(1'b0, 8'h00, 1'b0, 1'b0); end
      endcase
      e = sb.pop_front(); o = observed(); checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL stall_handshake[%0d]: got %p required %p", i, o, e);
      end
    end
  endtask

  task automatic test_jump_vs_stall();
    snap_t e, o;
    sb.push_back(mk(8'h70, 1'b0, 1'b1, 1'b0, 8'd3));
    tick(1'b1, 8'h70, 1'b1, 1'b0);
    e = sb.pop_front(); o = observed(); checks++;
    if (o !== e) begin
      errors++;
      $display("[TB] FAIL jump_over_stall: got %p required %p", o, e);
    end
    sb.push_back(mk(8'h70, 1'b0, 1'b1, 1'b0, 8'd3));
    tick(1'b1, 8'h10, 1'b0, 1'b1);
    e = sb.pop_front(); o = observed(); checks++;
    if (o !== e) begin
      errors++;
      $display("[TB] FAIL jump_in_flush: got %p required %p", o, e);
    end
    sb.push_back(mk(8'h70, 1'b1, 1'b0, 1'b0, 8'd3));
    tick(1'b0, 8'h00, 1'b0, 1'b0);
    e = sb.pop_front(); o = observed(); checks++;
    if (o !== e) begin
      errors++;
      $display("[TB] FAIL flush_exit: got %p required %p", o, e);
    end
  endtask

  task automatic test_halt_sequential();
    snap_t e, o;
    logic [7:0] exp_pc [4] = '{8'h74, 8'h78, 8'h7C, 8'h80};
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk(exp_pc[i], (i < 3) ? 1'b1 : 1'b0, 1'b0, (i == 3) ? 1'b1 : 1'b0, 8'd3));
      tick(1'b0, 8'h00, 1'b0, 1'b1);
      e = sb.pop_front(); o = observed(); checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL halt_seq[%0d]: got %p required %p", i, o, e);
      end
    end
    for (int i = 0; i < 2; i++) begin
      sb.push_back(mk(8'h80, 1'b0, 1'b0, 1'b1, 8'd3));
      tick(1'b1, 8'h10, 1'b0, 1'b1);
      e = sb.pop_front(); o = observed(); checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL halt_frozen[%0d]: got %p required %p", i, o, e);
      end
    end
  endtask

  task automatic test_halt_jump();
    snap_t e, o;
    restart();
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk(8'h80, 1'b0, (i < 2) ? 1'b1 : 1'b0, (i >= 2) ? 1'b1 : 1'b0, 8'd1));
      tick((i == 0) ? 1'b1 : 1'b0, 8'h80, 1'b0, 1'b1);
      e = sb.pop_front(); o = observed(); checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL halt_jump[%0d]: got %p required %p", i, o, e);
      end
    end
  endtask

  task automatic test_wrap();
    snap_t e, o;
    restart();
    for (int i = 0; i < 4; i++) begin
      if (i < 3)
        sb.push_back(mk(8'hFC, (i == 2) ? 1'b1 : 1'b0, (i < 2) ? 1'b1 : 1'b0, 1'b0, 8'd1));
      else
        sb.push_back(mk(8'h00, 1'b1, 1'b0, 1'b0, 8'd1));
      tick((i == 0) ? 1'b1 : 1'b0, 8'hFC, 1'b0, (i == 3) ? 1'b1 : 1'b0);
      e = sb.pop_front(); o = observed(); checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL wrap[%0d]: got %p required %p", i, o, e);
      end
    end
  endtask

  task automatic test_async_reset();
    snap_t e, o;
    restart();
    sb.push_back(mk(8'h20, 1'b0, 1'b1, 1'b0, 8'd1));
    tick(1'b1, 8'h20, 1'b0, 1'b1);
    e = sb.pop_front(); o = observed(); checks++;
    if (o !== e) begin
      errors++;
      $display("[TB] FAIL pre_reset_flush: got %p required %p", o, e);
    end
    #2;
    rst_n = 1'b0;
    #1;
    sb.push_back(mk(8'h04, 1'b0, 1'b0, 1'b0, 8'd0));
    e = sb.pop_front(); o = observed(); checks++;
    if (o !== e) begin
      errors++;
      $display("[TB] FAIL async_reset: got %p required %p", o, e);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_saturation();
    snap_t e, o;
    logic [7:0] tgt;
    int exp_jc = 0;
    restart();
    for (int j = 0; j < 260; j++) begin
      tgt = 8'($urandom_range(0, 31) * 4);
      if (exp_jc < 255) exp_jc++;
      sb.push_back(mk(tgt, 1'b0, 1'b1, 1'b0, 8'(exp_jc)));
      tick(1'b1, tgt, 1'b0, 1'b1);
      e = sb.pop_front(); o = observed(); checks++;
      if (o !== e) begin
        errors++;
        $display("[TB] FAIL saturate[%0d]: got %p required %p", j, o, e);
      end
      tick(1'b1, 8'hFC, 1'b1, 1'b1);
      tick(1'b1, 8'hFC, 1'b0, 1'b1);
    end
    sb.push_back(mk(8'h00, 1'b0, 1'b0, 1'b0, 8'd255));
    e = sb.pop_front(); checks++;
    if (jump_count !== e.jc) begin
      errors++;
      $display("[TB] FAIL saturate_final: got %0d required %0d", jump_count, e.jc);
    end
  endtask

  initial begin
    test_reset();
    test_free_run();
    test_jump();
    test_stall_handshake();
    test_jump_vs_stall();
    test_halt_sequential();
    test_halt_jump();
    test_wrap();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter sequencer that consumes the branch-comparator outputs (`senable` jump request plus 8-bit target `etq`) and drives the instruction-fetch address. It steps the PC through sequential fetches under an instruction-memory ready handshake and honours hazard stalls. On a taken jump it redirects to the target and inserts a fixed number of flush bubbles. It stops at the program exit address. It sits between the branch/compare unit and instruction memory in the single-cycle-issue datapath.

## Interface
Parameters:
- `PC_W`, 8: PC and target width.
- `RESET_PC`, 8'h04: PC after reset (`main`).
- `PC_STEP`, 4: sequential increment.
- `FLUSH_CYCLES`, 2: bubble cycles after a taken jump. Legal range 1..15.
- `HALT_PC`, 8'h80: exit address. Reaching it halts fetch.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `senable`, in, 1: jump request from the comparator, sampled each edge.
- `etq`, in, PC_W: jump target, valid when `senable`=1.
- `stall`, in, 1: hazard stall. Holds PC and suppresses the fetch request.
- `imem_ready`, in, 1: instruction memory accepts the current fetch.
- `pc`, out, PC_W: current fetch address (registered).
- `fetch_req`, out, 1: fetch request for `pc`.
- `flush`, out, 1: kill younger in-flight instructions.
- `halted`, out, 1: program finished.
- `jump_count`, out, 8: taken-jump counter. Saturates at 255.

## Operation
- States are FETCH, FLUSH and HALT. Reset state is FETCH.
- Reset values: `pc`=RESET_PC, `flush`=0, `halted`=0, `jump_count`=0, flush counter=0. While `rst_n`=0, `fetch_req`=0.
- `fetch_req` = (state==FETCH) & ~`stall` & `rst_n`.
- `flush` = (state==FLUSH).
- `halted` = (state==HALT).
- FETCH priority, highest first:
  1. `senable`=1: `pc`<=`etq`. Flush counter <= FLUSH_CYCLES-1. `jump_count`++ unless it is 255. Next state FLUSH. The jump wins over `stall` and over `imem_ready`, and the fetch accepted in that cycle is discarded.
  2. `stall`=1: hold all state.
  3. `imem_ready`=1 (with `fetch_req`=1): `pc`<=`pc`+PC_STEP, modulo 2^PC_W (0xFC+4 wraps to 0x00). If the new value equals HALT_PC, next state is HALT.
  4. Otherwise hold. The request stays asserted until accepted.
- FLUSH:
  - `senable`, `stall` and `imem_ready` are ignored. A jump from a killed instruction is never taken.
  - The counter decrements each cycle.
  - At counter==0 the next state is HALT if `pc`==HALT_PC, else FETCH.
- HALT: all inputs are ignored and `pc` is frozen. Only `rst_n` exits this state.
- Reset asserted mid-operation, in any state, returns to the reset values immediately (asynchronously).

## Timing
- Jump latency: with `senable` high at edge N, `pc`=`etq` and `flush`=1 after edge N. `flush` stays high for exactly FLUSH_CYCLES cycles. `fetch_req` at the target rises on the cycle after the last flush cycle (if `stall`=0).
- Sequential fetch: one PC advance per cycle while `imem_ready`=1 and `stall`=0, so full throughput is one fetch per clock.
- `stall` acts combinationally on `fetch_req` in the same cycle and on PC update at the next edge.
- HALT entry: `halted` rises the cycle after the edge at which `pc` becomes HALT_PC (sequential path). On the jump path it rises after the FLUSH cycles.
- All registered outputs change only on the rising `clk` edge, except the asynchronous reset.

## Test plan
- Reset then free-run: release `rst_n`, hold `imem_ready`=1 and `stall`=0 -> `pc` reads 0x04, 0x08, 0x0C, 0x10 on successive cycles, with `fetch_req`=1 throughout.
- Taken jump: at `pc`=0x10 pulse `senable`=1 with `etq`=0x38 -> next cycle `pc`=0x38 and `flush`=1 for 2 cycles, `fetch_req`=0 during them, then `fetch_req`=1 at 0x38, and `jump_count`=1.
- Stall and handshake: `stall`=1 for 3 cycles at `pc`=0x50 -> `pc` holds 0x50 and `fetch_req`=0. Then `stall`=0 with `imem_ready`=0 for 2 cycles -> `pc` holds 0x50 with `fetch_req`=1, then advances to 0x54 once `imem_ready`=1.
- Jump vs stall and jump during flush: `senable`=1 with `stall`=1 and `etq`=0x70 -> jump is taken. A second `senable` pulse with `etq`=0x10 during FLUSH -> ignored, `pc` stays 0x70 and `jump_count` increments only once.
- Halt: sequential fetch from 0x7C with `imem_ready`=1 -> `pc`=0x80, then `halted`=1 and `fetch_req`=0. After that, `senable`=1 has no effect. Separately, a jump to `etq`=0x80 -> 2 flush cycles, then `halted`=1.
- Async reset mid-flush and counter saturation: drop `rst_n` during FLUSH -> all outputs return to their reset values at once, without waiting for a clock edge. 260 taken jumps -> `jump_count` stops at 255.
